inst_prefetch_queue: RTL and testbench

- FIFO buffer between the Fetch stage and the Decode stage.
- Absorbs Fetch/Decode rate mismatch and lets Fetch run ahead by up to DEPTH instructions while Decode stalls on hazards.
- Supplies each instruction with its PC.
- Discards all buffered instructions on a taken branch or jump, via flush.

---
 rtl/inst_prefetch_queue.sv | 139 +++++++++++++
 tb/tb_inst_prefetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue
//
// FIFO between the Fetch and Decode stages. It absorbs rate mismatch so Fetch
// can run up to DEPTH instructions ahead while Decode stalls. Each entry
// carries its instruction word together with its PC. A taken branch or jump
// raises flush, which discards every buffered entry.
//
// Optional feature: define IQ_BYPASS_EN to enable the empty-queue bypass.
// When the queue is empty, an instruction that Decode accepts in the same cycle
// passes straight from in_* to out_* with zero latency and is never written.
//
// Ports:
//   clk        core clock
//   rst        asynchronous, active-low reset
//   flush      synchronous discard of all entries; overrides push and pop
//   in_valid   Fetch presents an instruction
//   in_ready   queue can accept an entry (depends on registered count only)
//   in_inst    fetched instruction
//   in_pc      PC of the fetched instruction
//   out_valid  head entry is valid for Decode
//   out_ready  Decode consumes the head this cycle
//   out_inst   head instruction (0 when nothing is valid)
//   out_pc     head PC (0 when nothing is valid)
//   count      current occupancy
// -----------------------------------------------------------------------------
module inst_prefetch_queue #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INST_W-1:0]        in_inst,
    input  logic [ADDR_W-1:0]        in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_W-1:0]        out_inst,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    logic empty;
    logic bypass;
    logic push;
    logic pop;

    assign empty = (count_q == '0);

`ifdef IQ_BYPASS_EN
    // Only taken when Decode accepts in the same cycle; otherwise the entry is
    // written normally and shows up at the head one cycle later.
    assign bypass = empty && in_valid && out_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A full queue refuses a push even when the head is popped in the same
    // cycle, which keeps in_ready off the out_ready path.
    assign in_ready = (count_q != CntFull);

    assign push = in_valid && in_ready && !flush && !bypass;
    assign pop  = !empty && out_ready && !flush;

    assign count = count_q;

    always_comb begin
        out_valid = 1'b0;
        out_inst  = '0;
        out_pc    = '0;
        if (!empty) begin
            out_valid = 1'b1;
            out_inst  = mem_inst[rd_ptr_q];
            out_pc    = mem_pc[rd_ptr_q];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_inst  = in_inst;
            out_pc    = in_pc;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (PtrW + 1)'(1);
                2'b01:   count_d = count_q - (PtrW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; entries are only observable while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr_q] <= in_inst;
            mem_pc[wr_ptr_q]   <= in_pc;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [7:0]  in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [7:0]  out_pc;
    logic [2:0]  count;

    inst_prefetch_queue #(
        .INST_W(32),
        .ADDR_W(8),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_inst  (in_inst),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_pc   (out_pc),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [7:0]  pc;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [7:0]  pc;
        logic        ordy;
        logic        fl;
        int          exp_cnt;
    } vec_t;

    ent_t sb[$];
    int   m_cnt;
    int   checks;
    int   failures;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered just after a rising edge: drive, check before the next edge,
    // update the scoreboard model, then advance past the edge.
    task automatic cyc(input logic iv, input logic [31:0] ii, input logic [7:0] ip,
                       input logic ordy, input logic fl, input int exp_cnt);
        logic        ev;
        logic [31:0] ei;
        logic [7:0]  ep;
        logic        byp;
        logic        do_push;
        logic        do_pop;
        ent_t        e;
        in_valid  = iv;
        in_inst   = ii;
        in_pc     = ip;
        out_ready = ordy;
        flush     = fl;
        byp = 1'b0;
`ifdef IQ_BYPASS_EN
        byp = (m_cnt == 0) && iv && ordy && !fl;
`endif
        ev = 1'b0;
        ei = '0;
        ep = '0;
        if (m_cnt != 0) begin
            ev = 1'b1;
            ei = sb[0].inst;
            ep = sb[0].pc;
        end else if (byp) begin
            ev = 1'b1;
            ei = ii;
            ep = ip;
        end
        @(negedge clk);
        chk("count", 32'(count), 32'(m_cnt));
        chk("count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
        chk("in_ready", 32'(in_ready), 32'(m_cnt != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_inst", out_inst, ei);
        chk("out_pc", 32'(out_pc), 32'(ep));
        if (exp_cnt >= 0) chk("tbl_count", 32'(count), 32'(exp_cnt));
        if (fl) begin
            sb.delete();
        end else begin
            do_pop  = (m_cnt != 0) && ordy;
            do_push = iv && (m_cnt != DEPTH) && !byp;
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                e.inst = ii;
                e.pc   = ip;
                sb.push_back(e);
            end
        end
        m_cnt = sb.size();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_cnt     = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        //            iv    inst    pc     ordy  fl   count seen this cycle
        tbl[0]  = '{1'b1, 32'h11, 8'h00, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 32'h22, 8'h01, 1'b0, 1'b0, 1};
        tbl[2]  = '{1'b1, 32'h33, 8'h02, 1'b0, 1'b0, 2};
        tbl[3]  = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 3};
        tbl[4]  = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 2};
        tbl[5]  = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1};
        tbl[6]  = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b1, 32'h61, 8'h03, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b1, 32'h62, 8'h04, 1'b0, 1'b0, 1};
        tbl[9]  = '{1'b1, 32'h63, 8'h05, 1'b0, 1'b0, 2};
        tbl[10] = '{1'b1, 32'h64, 8'h06, 1'b0, 1'b0, 3};
        tbl[11] = '{1'b1, 32'h65, 8'h07, 1'b0, 1'b0, 4};  // full: refused
        tbl[12] = '{1'b1, 32'h65, 8'h07, 1'b1, 1'b0, 4};  // pop only, push refused
        tbl[13] = '{1'b1, 32'h65, 8'h07, 1'b0, 1'b0, 3};  // now accepted
        tbl[14] = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 4};
        tbl[15] = '{1'b1, 32'h44, 8'h08, 1'b1, 1'b1, 3};  // flush drops 0x44
        tbl[16] = '{1'b0, 32'h00, 8'h00, 1'b0, 1'b0, 0};

        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #11;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].iv, tbl[i].inst, tbl[i].pc, tbl[i].ordy, tbl[i].fl, tbl[i].exp_cnt);
        end

        // Steady stream longer than DEPTH to wrap both pointers.
        for (int i = 0; i < 20; i++) begin
`ifdef IQ_BYPASS_EN
            cyc(1'b1, 32'h100 + 32'(i), 8'(i), 1'b1, 1'b0, 0);
`else
            cyc(1'b1, 32'h100 + 32'(i), 8'(i), 1'b1, 1'b0, (i == 0) ? 0 : 1);
`endif
        end
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, -1);
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 0);

        // Flush on an empty queue leaves it empty.
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 0);
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 0);

        // Asynchronous reset with two entries held.
        cyc(1'b1, 32'h71, 8'h20, 1'b0, 1'b0, 0);
        cyc(1'b1, 32'h72, 8'h21, 1'b0, 1'b0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_out_inst", out_inst, 32'd0);
        sb.delete();
        m_cnt = 0;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 32'h81, 8'h30, 1'b0, 1'b0, 0);
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1);
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 0);

`ifdef IQ_BYPASS_EN
        // Bypass: same-cycle pass-through, then stored when Decode stalls.
        cyc(1'b1, 32'h55, 8'h10, 1'b1, 1'b0, 0);
        cyc(1'b1, 32'h55, 8'h10, 1'b0, 1'b0, 0);
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1);
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1);
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
